// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: owns the fetch PC, issues in-order imem requests, buffers PC-tagged instructions, flushes on redirect
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = $clog2(2 * DEPTH + 1);
    localparam int SW = DW + 1;
    localparam logic [DW-1:0] DROP_MAX = DW'(2 * DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   q_data [DEPTH];
    logic [31:0]   q_pc [DEPTH];
    logic [31:0]   pend_pc [DEPTH];
    logic [AW-1:0] q_head, q_tail, p_head, p_tail;
    logic [CW-1:0] count, inflight;
    logic [DW-1:0] drop, drop_next;
    logic [SW-1:0] used, total;
    logic          accept, rsp_take, pop;

    // Credit covers queued, in-flight and still-to-be-dropped responses so a response always finds a free slot
    always_comb begin
        used           = SW'(count) + SW'(inflight) + SW'(drop);
        imem_req_valid = !reset && !redirect_valid && (used < SW'(DEPTH));
        imem_req_addr  = fetch_pc;
        accept         = imem_req_valid && imem_req_ready;
        rsp_take       = imem_rsp_valid && (drop == '0);
        inst_valid     = count != '0;
        pop            = inst_valid && inst_ready;
        inst_data      = inst_valid ? q_data[q_head] : '0;
        inst_pc        = inst_valid ? q_pc[q_head] : '0;
        total          = SW'(drop) + SW'(inflight) - SW'(imem_rsp_valid);
        drop_next      = (total > SW'(2 * DEPTH)) ? DROP_MAX : total[DW-1:0];
    end

    // Control state: fetch PC, pointers and counters; redirect clears everything and converts in-flight work to drops
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            q_head   <= '0;
            q_tail   <= '0;
            p_head   <= '0;
            p_tail   <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~32'h3;
            q_head   <= '0;
            q_tail   <= '0;
            p_head   <= '0;
            p_tail   <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= drop_next;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
                p_tail   <= p_tail + AW'(1);
            end
            if (rsp_take) begin
                p_head <= p_head + AW'(1);
                q_tail <= q_tail + AW'(1);
            end
            if (pop) q_head <= q_head + AW'(1);
            count    <= count + CW'(rsp_take) - CW'(pop);
            inflight <= inflight + CW'(accept) - CW'(rsp_take);
            if (imem_rsp_valid && drop != '0) drop <= drop - DW'(1);
        end
    end

    // Storage for pending request PCs and the PC-tagged instruction queue; stale writes are harmless after a flush
    always_ff @(posedge clock) begin
        if (accept) pend_pc[p_tail] <= fetch_pc;
        if (rsp_take) begin
            q_data[q_tail] <= imem_rsp_data;
            q_pc[q_tail]   <= pend_pc[p_head];
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: randomized scenarios against an in-order memory model and an expected-PC-stream reference
module tb_instr_fetch_queue;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    instr_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] a; int due; } req_t;
    req_t        mq[$];
    int          cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
    int          vectors = 0, miscompares = 0;
    logic [31:0] exp_pc = RESET_PC, exp_req = RESET_PC;
    logic        o_acc, o_pop, o_rsp, o_rv;
    logic [31:0] o_addr, o_pc, o_data, e_pc, e_req;

    function automatic logic [31:0] f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // One clock: memory model drives the response, outputs are captured with the model's expectations, then models advance
    task automatic step(input logic redir, input logic [31:0] rpc, input logic rq, input logic ir);
        int d;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rq;
        inst_ready     = ir;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (mq.size() > 0) begin
            if (mq[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = f(mq[0].a);
            end
        end
        #1;
        o_rv   = imem_req_valid;
        o_acc  = imem_req_valid && rq;
        o_addr = imem_req_addr;
        o_pop  = inst_valid && ir;
        o_pc   = inst_pc;
        o_data = inst_data;
        o_rsp  = imem_rsp_valid;
        e_pc   = exp_pc;
        e_req  = exp_req;
        @(posedge clock);
        #1;
        if (reset) begin
            mq.delete();
            exp_pc   = RESET_PC;
            exp_req  = RESET_PC;
            last_due = cyc;
        end else begin
            if (o_rsp) void'(mq.pop_front());
            if (o_acc) begin
                d = cyc + int'($urandom_range(lat_max, lat_min));
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                mq.push_back('{o_addr, d});
                exp_req = exp_req + 32'd4;
            end
            if (o_pop) exp_pc = exp_pc + 32'd4;
            if (redir) begin
                exp_pc  = rpc & ~32'h3;
                exp_req = rpc & ~32'h3;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        vectors++;
        if ({imem_req_valid, inst_valid, inst_data, inst_pc} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rv=%b iv=%b data=%h pc=%h expected all zero", imem_req_valid, inst_valid, inst_data, inst_pc);
        end
        vectors++;
        if (imem_req_addr !== RESET_PC) begin
            miscompares++;
            $display("FAIL reset_addr: got %h expected %h", imem_req_addr, RESET_PC);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (imem_req_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_req_valid: got %b expected 1", imem_req_valid);
        end
    endtask

    task automatic test_stream();
        int pops = 0;
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 1, 1);
            if (o_acc) begin vectors++; if (o_addr !== e_req) begin miscompares++; $display("FAIL stream_addr: got %h expected %h", o_addr, e_req); end end
            if (o_pop) begin pops++; vectors++; if (o_pc !== e_pc || o_data !== f(e_pc)) begin miscompares++; $display("FAIL stream_inst: got pc %h data %h expected pc %h data %h", o_pc, o_data, e_pc, f(e_pc)); end end
        end
        vectors++;
        if (pops < 27) begin
            miscompares++;
            $display("FAIL stream_rate: got %0d pops expected >= 27", pops);
        end
    endtask

    task automatic test_backpressure();
        int accs = 0;
        logic seen = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 0);
            if (o_acc) accs++;
        end
        vectors++;
        if (accs !== 4) begin miscompares++; $display("FAIL bp_accepts: got %0d expected 4", accs); end
        vectors++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL bp_stall: got rv=%b addr=%h expected rv=0 addr=00000010", imem_req_valid, imem_req_addr);
        end
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, 1);
            if (o_acc && !seen) begin
                seen = 1'b1;
                vectors++;
                if (o_addr !== 32'h10) begin miscompares++; $display("FAIL bp_resume: got %h expected 00000010", o_addr); end
            end
            if (o_acc) begin vectors++; if (o_addr !== e_req) begin miscompares++; $display("FAIL bp_addr: got %h expected %h", o_addr, e_req); end end
            if (o_pop) begin vectors++; if (o_pc !== e_pc || o_data !== f(e_pc)) begin miscompares++; $display("FAIL bp_inst: got pc %h data %h expected pc %h data %h", o_pc, o_data, e_pc, f(e_pc)); end end
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL bp_resume_timeout: got no request expected one within 20 cycles"); end
    endtask

    task automatic test_req_stall();
        int pops = 0;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            step(0, 0, (i % 4 == 0) || (i % 4 == 3), 1);
            if (i == 1 || i == 2) begin
                vectors++;
                if (o_rv !== 1'b1 || o_addr !== 32'h4) begin miscompares++; $display("FAIL stall_hold: got rv=%b addr=%h expected rv=1 addr=00000004", o_rv, o_addr); end
            end
            if (o_acc) begin vectors++; if (o_addr !== e_req) begin miscompares++; $display("FAIL stall_addr: got %h expected %h", o_addr, e_req); end end
            if (o_pop) begin pops++; vectors++; if (o_pc !== e_pc || o_data !== f(e_pc)) begin miscompares++; $display("FAIL stall_inst: got pc %h data %h expected pc %h data %h", o_pc, o_data, e_pc, f(e_pc)); end end
        end
        vectors++;
        if (pops < 10) begin miscompares++; $display("FAIL stall_rate: got %0d pops expected >= 10", pops); end
    endtask

    task automatic test_redirect_drop();
        logic got = 1'b0;
        do_reset();
        lat_min = 3; lat_max = 3;
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        vectors++;
        if (mq.size() !== 2) begin miscompares++; $display("FAIL drop_setup: got %0d in flight expected 2", mq.size()); end
        step(1, 32'h103, 1, 1);
        for (int i = 0; i < 30 && !got; i++) begin
            step(0, 0, 1, 1);
            if (o_acc) begin vectors++; if (o_addr !== e_req) begin miscompares++; $display("FAIL drop_addr: got %h expected %h", o_addr, e_req); end end
            if (o_pop) begin
                got = 1'b1;
                vectors++;
                if (o_pc !== 32'h100 || o_data !== f(32'h100)) begin miscompares++; $display("FAIL drop_first: got pc %h data %h expected pc 00000100 data %h", o_pc, o_data, f(32'h100)); end
            end
        end
        vectors++;
        if (!got) begin miscompares++; $display("FAIL drop_timeout: got no instruction expected pc 00000100"); end
        lat_min = 1; lat_max = 1;
    endtask

    task automatic test_back_to_back();
        logic got = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) step(0, 0, 1, 1);
        step(1, 32'h200, 1, 1);
        vectors++;
        if (o_rsp !== 1'b1 || o_pop !== 1'b1) begin miscompares++; $display("FAIL b2b_setup: got rsp=%b pop=%b expected 1 1", o_rsp, o_pop); end
        vectors++;
        if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_flush1: got inst_valid %b expected 0", inst_valid); end
        step(1, 32'h300, 1, 1);
        vectors++;
        if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_flush2: got inst_valid %b expected 0", inst_valid); end
        for (int i = 0; i < 30 && !got; i++) begin
            step(0, 0, 1, 1);
            if (o_acc) begin vectors++; if (o_addr !== e_req) begin miscompares++; $display("FAIL b2b_addr: got %h expected %h", o_addr, e_req); end end
            if (o_pop) begin
                got = 1'b1;
                vectors++;
                if (o_pc !== 32'h300 || o_data !== f(32'h300)) begin miscompares++; $display("FAIL b2b_first: got pc %h data %h expected pc 00000300 data %h", o_pc, o_data, f(32'h300)); end
            end
        end
        vectors++;
        if (!got) begin miscompares++; $display("FAIL b2b_timeout: got no instruction expected pc 00000300"); end
    endtask

    task automatic test_wrap_reset();
        logic [31:0] want [3];
        int n = 0;
        want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
        step(1, 32'hFFFF_FFF8, 1, 1);
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 1, 1);
            if (o_acc && n < 3) begin
                vectors++;
                if (o_addr !== want[n]) begin miscompares++; $display("FAIL wrap_addr%0d: got %h expected %h", n, o_addr, want[n]); end
                n++;
            end
            if (o_pop) begin vectors++; if (o_pc !== e_pc || o_data !== f(e_pc)) begin miscompares++; $display("FAIL wrap_inst: got pc %h data %h expected pc %h data %h", o_pc, o_data, e_pc, f(e_pc)); end end
        end
        vectors++;
        if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_prereset: got inst_valid %b expected 1", inst_valid); end
        reset = 1'b1;
        step(0, 0, 1, 1);
        vectors++;
        if (inst_valid !== 1'b0 || imem_req_addr !== RESET_PC) begin
            miscompares++;
            $display("FAIL midreset: got iv=%b addr=%h expected iv=0 addr=%h", inst_valid, imem_req_addr, RESET_PC);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 1);
            if (o_acc) begin vectors++; if (o_addr !== e_req) begin miscompares++; $display("FAIL postreset_addr: got %h expected %h", o_addr, e_req); end end
            if (o_pop) begin vectors++; if (o_pc !== e_pc || o_data !== f(e_pc)) begin miscompares++; $display("FAIL postreset_inst: got pc %h data %h expected pc %h data %h", o_pc, o_data, e_pc, f(e_pc)); end end
        end
    endtask

    task automatic test_random();
        int pops = 0;
        logic redir;
        do_reset();
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 600; i++) begin
            redir = ($urandom % 16) == 0;
            step(redir, $urandom, ($urandom % 4) != 0, ($urandom % 3) != 0);
            vectors++;
            if (mq.size() > DEPTH) begin miscompares++; $display("FAIL rand_credit: got %0d outstanding expected <= %0d", mq.size(), DEPTH); end
            if (o_acc) begin vectors++; if (o_addr !== e_req) begin miscompares++; $display("FAIL rand_addr: got %h expected %h", o_addr, e_req); end end
            if (o_pop) begin pops++; vectors++; if (o_pc !== e_pc || o_data !== f(e_pc)) begin miscompares++; $display("FAIL rand_inst: got pc %h data %h expected pc %h data %h", o_pc, o_data, e_pc, f(e_pc)); end end
        end
        vectors++;
        if (pops < 100) begin miscompares++; $display("FAIL rand_progress: got %0d pops expected >= 100", pops); end
        lat_min = 1; lat_max = 1;
    endtask

    initial begin
        @(posedge clock);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_req_stall();
        test_redirect_drop();
        test_back_to_back();
        test_wrap_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
